// File: rtl/fpu_mon_pkg.sv
// Shared definitions for the FPU check monitor: channel FSM states,
// default parameter values and the saturating counter helper.
package fpu_mon_pkg;

  localparam int DEF_NUM_CH  = 2;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 256;
  localparam int DEF_PHASE_W = 8;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_WAIT = 2'd1,
    CH_TOUT = 2'd2
  } ch_state_e;

  // Add inc to val and clamp at 2^w-1 (w <= 32); callers truncate to w bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] inc,
                                          input int          w);
    logic [32:0] sum;
    logic [32:0] maxv;
    maxv = (33'd1 << w) - 33'd1;
    sum  = {1'b0, val} + {1'b0, inc};
    return (sum > maxv) ? maxv[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/fpu_mon_channel.sv
// One monitored FPU request channel: IDLE/WAIT/TOUT handshake FSM,
// timeout timer, saturating tb/assertion error counters and, when
// FPU_MON_LATENCY_EN is defined, a max req-to-done latency register.
module fpu_mon_channel
  import fpu_mon_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             clr,
  input  logic             req,
  input  logic             done,
  input  logic             etb,
  input  logic             eas,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] cnt_tb,
  output logic [CNT_W-1:0] cnt_as,
  output logic [2:0]       inc_tot,
  output logic             tout_nxt
`ifdef FPU_MON_LATENCY_EN
  ,
  output logic [CNT_W-1:0] max_lat
`endif
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  ch_state_e        st, st_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic             proto_err;
  logic             tout_evt;
  logic [1:0]       inc_tb, inc_as;
`ifdef FPU_MON_LATENCY_EN
  logic             lat_vld;
  logic [31:0]      lat;
  logic [31:0]      lat_sat;
`endif

  // Next-state, timer and per-cycle error-event decode.
  always_comb begin
    st_n      = st;
    tmr_n     = tmr;
    proto_err = 1'b0;
    tout_evt  = 1'b0;
`ifdef FPU_MON_LATENCY_EN
    lat_vld   = 1'b0;
    lat       = 32'd0;
`endif
    case (st)
      CH_IDLE: begin
        if (req) begin
          // A done alongside the req is a zero-latency completion.
          if (!done) begin
            st_n  = CH_WAIT;
            tmr_n = '0;
          end
`ifdef FPU_MON_LATENCY_EN
          else begin
            lat_vld = 1'b1;
          end
`endif
        end else if (done) begin
          proto_err = 1'b1;
        end
      end
      CH_WAIT: begin
        if (done) begin
`ifdef FPU_MON_LATENCY_EN
          lat_vld = 1'b1;
          lat     = 32'(tmr) + 32'd1;
`endif
          st_n  = req ? CH_WAIT : CH_IDLE;
          tmr_n = '0;
        end else if (req) begin
          proto_err = 1'b1;
          tmr_n     = '0;
        end else if (tmr == TMR_LAST) begin
          st_n     = CH_TOUT;
          tout_evt = 1'b1;
          tmr_n    = '0;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      CH_TOUT: begin
        st_n = CH_TOUT;
      end
      default: begin
        st_n  = CH_IDLE;
        tmr_n = '0;
      end
    endcase
  end

  assign inc_tb   = {1'b0, etb} + {1'b0, tout_evt};
  assign inc_as   = {1'b0, eas} + {1'b0, proto_err};
  assign inc_tot  = clr ? 3'd0 : ({1'b0, inc_tb} + {1'b0, inc_as});
  assign tout_nxt = ~clr & (st_n == CH_TOUT);
  assign busy     = (st == CH_WAIT);
  assign timeout  = (st == CH_TOUT);
`ifdef FPU_MON_LATENCY_EN
  assign lat_sat  = sat_inc(lat, 32'd0, CNT_W);
`endif

  // State, timer and saturating counters; clr discards the cycle's events.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      st      <= CH_IDLE;
      tmr     <= '0;
      cnt_tb  <= '0;
      cnt_as  <= '0;
`ifdef FPU_MON_LATENCY_EN
      max_lat <= '0;
`endif
    end else if (clr) begin
      st      <= CH_IDLE;
      tmr     <= '0;
      cnt_tb  <= '0;
      cnt_as  <= '0;
`ifdef FPU_MON_LATENCY_EN
      max_lat <= '0;
`endif
    end else begin
      st     <= st_n;
      tmr    <= tmr_n;
      cnt_tb <= CNT_W'(sat_inc(32'(cnt_tb), 32'(inc_tb), CNT_W));
      cnt_as <= CNT_W'(sat_inc(32'(cnt_as), 32'(inc_as), CNT_W));
`ifdef FPU_MON_LATENCY_EN
      if (lat_vld && (lat_sat > 32'(max_lat)))
        max_lat <= CNT_W'(lat_sat);
`endif
    end
  end

endmodule

// File: rtl/fpu_check_monitor.sv
// Multi-channel FPU handshake/error monitor: per-channel watchdogs and
// counters, a saturating error total, test-phase register and irq.
// Optional max-latency tracking is enabled by defining FPU_MON_LATENCY_EN.
module fpu_check_monitor
  import fpu_mon_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int PHASE_W = DEF_PHASE_W
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    phase_we,
  input  logic [PHASE_W-1:0]      phase_in,
  input  logic                    clr,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH-1:0]       done_valid,
  input  logic [NUM_CH-1:0]       err_tb,
  input  logic [NUM_CH-1:0]       err_as,
  output logic [PHASE_W-1:0]      phase_out,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH*CNT_W-1:0] err_cnt_tb,
  output logic [NUM_CH*CNT_W-1:0] err_cnt_as,
  output logic [CNT_W-1:0]        err_total,
  output logic                    irq
`ifdef FPU_MON_LATENCY_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] max_lat
`endif
);

  logic [NUM_CH*3-1:0] inc_vec;
  logic [NUM_CH-1:0]   tout_nxt;
  logic [7:0]          inc_sum;
  logic [CNT_W-1:0]    err_total_n;
  logic                irq_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fpu_mon_channel #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
    ) u_ch (
      .clk      (clk),
      .arst     (arst),
      .clr      (clr),
      .req      (req_valid[g]),
      .done     (done_valid[g]),
      .etb      (err_tb[g]),
      .eas      (err_as[g]),
      .busy     (busy[g]),
      .timeout  (timeout[g]),
      .cnt_tb   (err_cnt_tb[g*CNT_W +: CNT_W]),
      .cnt_as   (err_cnt_as[g*CNT_W +: CNT_W]),
      .inc_tot  (inc_vec[g*3 +: 3]),
      .tout_nxt (tout_nxt[g])
`ifdef FPU_MON_LATENCY_EN
      ,
      .max_lat  (max_lat[g*CNT_W +: CNT_W])
`endif
    );
  end

  // Sum of every channel's increments this cycle, then the saturated total.
  always_comb begin
    inc_sum = 8'd0;
    for (int i = 0; i < NUM_CH; i++)
      inc_sum = inc_sum + 8'(inc_vec[i*3 +: 3]);
    err_total_n = clr ? '0 : CNT_W'(sat_inc(32'(err_total), 32'(inc_sum), CNT_W));
    irq_n       = ~clr & ((|tout_nxt) | (err_total_n != '0));
  end

  // Error total and irq, both reflecting the state after this cycle's events.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      err_total <= '0;
      irq       <= 1'b0;
    end else begin
      err_total <= err_total_n;
      irq       <= irq_n;
    end
  end

  // Test-phase code register, independent of clr.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)
      phase_out <= '0;
    else if (phase_we)
      phase_out <= phase_in;
  end

endmodule

// File: tb/tb_fpu_check_monitor.sv
// Table-driven scoreboard bench for fpu_check_monitor
// (NUM_CH=2, CNT_W=4, TIMEOUT=8, PHASE_W=8).
module tb_fpu_check_monitor;

  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int PHASE_W = 8;

  typedef struct {
    logic [1:0] req, done, etb, eas;
    logic       clr;
    logic [1:0] busy, tout;
    logic [3:0] tb0, tb1, as0, as1, tot;
    logic       irq;
    logic [3:0] ml0, ml1;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    arst = 1'b0;
  logic                    phase_we = 1'b0;
  logic [PHASE_W-1:0]      phase_in = '0;
  logic                    clr = 1'b0;
  logic [NUM_CH-1:0]       req_valid = '0;
  logic [NUM_CH-1:0]       done_valid = '0;
  logic [NUM_CH-1:0]       err_tb = '0;
  logic [NUM_CH-1:0]       err_as = '0;
  logic [PHASE_W-1:0]      phase_out;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       timeout;
  logic [NUM_CH*CNT_W-1:0] err_cnt_tb;
  logic [NUM_CH*CNT_W-1:0] err_cnt_as;
  logic [CNT_W-1:0]        err_total;
  logic                    irq;
`ifdef FPU_MON_LATENCY_EN
  logic [NUM_CH*CNT_W-1:0] max_lat;
`endif

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  fpu_check_monitor #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .PHASE_W (PHASE_W)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .phase_we   (phase_we),
    .phase_in   (phase_in),
    .clr        (clr),
    .req_valid  (req_valid),
    .done_valid (done_valid),
    .err_tb     (err_tb),
    .err_as     (err_as),
    .phase_out  (phase_out),
    .busy       (busy),
    .timeout    (timeout),
    .err_cnt_tb (err_cnt_tb),
    .err_cnt_as (err_cnt_as),
    .err_total  (err_total),
    .irq        (irq)
`ifdef FPU_MON_LATENCY_EN
    ,
    .max_lat    (max_lat)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add(logic [1:0] r, logic [1:0] d, logic [1:0] et, logic [1:0] ea,
                              logic c, logic [1:0] b, logic [1:0] t,
                              logic [3:0] tb0, logic [3:0] tb1, logic [3:0] as0,
                              logic [3:0] as1, logic [3:0] tot, logic ir,
                              logic [3:0] ml0, logic [3:0] ml1);
    vec_t v;
    v.req = r; v.done = d; v.etb = et; v.eas = ea; v.clr = c;
    v.busy = b; v.tout = t; v.tb0 = tb0; v.tb1 = tb1; v.as0 = as0; v.as1 = as1;
    v.tot = tot; v.irq = ir; v.ml0 = ml0; v.ml1 = ml1;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    req_valid  = v.req;
    done_valid = v.done;
    err_tb     = v.etb;
    err_as     = v.eas;
    clr        = v.clr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    req_valid = '0; done_valid = '0; err_tb = '0; err_as = '0; clr = 1'b0;
    e = exp_q.pop_front();
    chk("busy",    idx, 32'(busy),              32'(e.busy));
    chk("timeout", idx, 32'(timeout),           32'(e.tout));
    chk("cnt_tb0", idx, 32'(err_cnt_tb[3:0]),   32'(e.tb0));
    chk("cnt_tb1", idx, 32'(err_cnt_tb[7:4]),   32'(e.tb1));
    chk("cnt_as0", idx, 32'(err_cnt_as[3:0]),   32'(e.as0));
    chk("cnt_as1", idx, 32'(err_cnt_as[7:4]),   32'(e.as1));
    chk("total",   idx, 32'(err_total),         32'(e.tot));
    chk("irq",     idx, 32'(irq),               32'(e.irq));
`ifdef FPU_MON_LATENCY_EN
    chk("max_lat0", idx, 32'(max_lat[3:0]),     32'(e.ml0));
    chk("max_lat1", idx, 32'(max_lat[7:4]),     32'(e.ml1));
`endif
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"},  0, 32'(busy),       32'd0);
    chk({nm, "_tout"},  0, 32'(timeout),    32'd0);
    chk({nm, "_cnttb"}, 0, 32'(err_cnt_tb), 32'd0);
    chk({nm, "_cntas"}, 0, 32'(err_cnt_as), 32'd0);
    chk({nm, "_total"}, 0, 32'(err_total),  32'd0);
    chk({nm, "_irq"},   0, 32'(irq),        32'd0);
  endtask

  initial begin
    vec_t v;
    // Expected post-edge outputs for each input cycle.
    // req done etb eas clr | busy tout tb0 tb1 as0 as1 tot irq ml0 ml1
    add(1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      add(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    add(1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    add(1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    add(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1, 1, 4, 0);
    add(1, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 1, 1, 4, 0);
    add(1, 0, 0, 0, 0,  1, 0, 0, 0, 2, 0, 2, 1, 4, 0);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0, 2, 0, 2, 1, 4, 0);
    add(2, 0, 0, 0, 0,  2, 0, 0, 0, 2, 0, 2, 1, 4, 0);
    for (int k = 0; k < 7; k++)
      add(0, 0, 0, 0, 0,  2, 0, 0, 0, 2, 0, 2, 1, 4, 0);
    add(0, 0, 0, 0, 0,  0, 2, 0, 1, 2, 0, 3, 1, 4, 0);
    add(2, 2, 0, 0, 0,  0, 2, 0, 1, 2, 0, 3, 1, 4, 0);
    add(0, 1, 0, 1, 0,  0, 2, 0, 1, 4, 0, 5, 1, 4, 0);
    add(0, 0, 3, 1, 0,  0, 2, 1, 2, 5, 0, 8, 1, 4, 0);
    add(0, 0, 3, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++)
      add(0, 0, 1, 0, 0,  0, 0, 4'((k > 15) ? 15 : k), 0, 0, 0,
          4'((k > 15) ? 15 : k), 1, 0, 0);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_phase", 0, 32'(phase_out), 32'd0);
    #2 arst = 1'b1;
    @(posedge clk);
    #1;

    // Phase write, which must survive every clr in the table.
    phase_we = 1'b1;
    phase_in = 8'h3C;
    @(posedge clk);
    #1;
    phase_we = 1'b0;
    phase_in = 8'h00;
    chk("phase_wr", 0, 32'(phase_out), 32'h3C);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      apply(v, i);
    end
    chk("phase_after_clr", 0, 32'(phase_out), 32'h3C);

    // Reset asserted mid-WAIT while a phase write is pending.
    req_valid = 2'b01;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk("pre_rst_busy", 0, 32'(busy), 32'd1);
    phase_we = 1'b1;
    phase_in = 8'hA5;
    #2 arst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_phase", 0, 32'(phase_out), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_phase", 0, 32'(phase_out), 32'd0);
    #2 arst = 1'b1;
    @(posedge clk);
    #1;
    phase_we = 1'b0;
    chk("rst_rel_phase", 0, 32'(phase_out), 32'hA5);
    chk_all_zero("rst_rel");
    repeat (TIMEOUT + 2) @(posedge clk);
    #1;
    chk_all_zero("rst_no_tout");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_check_monitor.md
Name: fpu_check_monitor

Overview:
Synthesizable multi-channel successor to the FPU bench interface's software error bookkeeping. It tracks the FPU operation request/done handshake per channel, runs a per-channel timeout watchdog, and keeps saturating testbench-style and assertion-style error counters plus a total. It also holds a hardware test-phase register. It sits beside the FPU datapath in both simulation and FPGA builds.

Parameters:
NUM_CH, 2, number of independent FPU request channels (1..8)
CNT_W, 16, width of every error counter
TIMEOUT, 256, cycles in WAIT before a timeout fires (2..2^20)
PHASE_W, 8, width of the test-phase code register

Ports:
clk  in  1  system clock, rising edge
arst  in  1  asynchronous reset, active-low
phase_we  in  1  load phase_in into phase register
phase_in  in  PHASE_W  new test-phase code
clr  in  1  synchronous clear of counters and sticky flags
req_valid  in  NUM_CH  per-channel operation issued (1-cycle pulse)
done_valid  in  NUM_CH  per-channel operation completed (1-cycle pulse)
err_tb  in  NUM_CH  per-channel data-mismatch report
err_as  in  NUM_CH  per-channel assertion-failure report
phase_out  out  PHASE_W  current test-phase code
busy  out  NUM_CH  channel in WAIT
timeout  out  NUM_CH  sticky per-channel timeout flag
err_cnt_tb  out  NUM_CH*CNT_W  per-channel tb error count, channel 0 in LSBs
err_cnt_as  out  NUM_CH*CNT_W  per-channel assertion/protocol error count
err_total  out  CNT_W  saturating sum of all error increments
irq  out  1  registered OR of all timeout bits and (err_total != 0)

Behaviour:
- Reset (arst low, async): all outputs 0, every channel in IDLE, timers 0.
- Per-channel FSM, states IDLE, WAIT, TOUT:
  - IDLE + req: go to WAIT, timer=0, busy=1 next cycle.
  - IDLE + done without req: spurious; err_cnt_as += 1; stay IDLE.
  - IDLE + req and done in the same cycle: a zero-latency op. Count it as a valid completion and stay IDLE.
  - WAIT + done: go to IDLE. If req is also high in that cycle, restart WAIT with timer=0 (back-to-back ops).
  - WAIT + req without done: overlapping request; err_cnt_as += 1; timer restarts at 0.
  - WAIT with timer==TIMEOUT-1 and no done: go to TOUT; timeout bit set; err_cnt_tb += 1. Timeout fires exactly TIMEOUT cycles after the req edge.
  - TOUT: ignores req and done; exits to IDLE only on clr.
- err_tb / err_as: each asserted bit adds 1 to that channel's counter that cycle. A protocol event plus an err_as pulse in the same cycle adds 2.
- All counters saturate at 2^CNT_W-1 and never wrap.
- err_total adds the popcount of all increments in a cycle, saturating.
- Counters, timeout and irq update one cycle after the event (registered outputs).
- clr: next cycle, all counters, timeout and irq are 0, and every channel is in IDLE. Events in the clr cycle are discarded. phase register is unaffected.
- phase_we: phase_out = phase_in next cycle. Independent of clr.
- Reset mid-operation: aborts WAIT, with no error counted.

Optional Feature:
FPU_MON_LATENCY_EN
- Defined: adds output max_lat (NUM_CH*CNT_W). Per channel, it holds the largest observed req-to-done latency in cycles: zero-latency = 0, next-cycle done = 1. Saturating; cleared by clr and reset; timeouts not recorded.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package fpu_mon_pkg: channel state enum (IDLE/WAIT/TOUT), a saturating-increment function with an increment-amount argument, and the default parameter constants.
- One sub-module, fpu_mon_channel: FSM, timer, two counters, and optional max-latency register.
- The top instantiates NUM_CH channels via generate and holds the total adder, phase register and irq.

Test Plan:
- Reset, then req ch0 at cycle 10, done at cycle 14 -> busy[0] high cycles 11-14, no errors; with the macro, max_lat[0]=4.
- TIMEOUT=8: req ch1, no done -> timeout[1]=1 eight cycles after req, err_cnt_tb[1]=1, err_total=1, irq=1. A later done is ignored.
- done on ch0 while IDLE, then req twice without done -> err_cnt_as[0]=2, err_total=2.
- CNT_W=4: err_tb[0] held high 20 cycles -> err_cnt_tb[0]=15 (saturated), err_total=15.
- err_tb=2'b11 and err_as=2'b01 in one cycle -> err_total +3; clr next cycle -> all counters 0, timeout 0, irq 0, phase_out unchanged.
- phase_we with phase_in=8'hA5 while arst is pulsed low mid-WAIT -> all outputs 0 and no error counted; after release, phase_we writes 8'hA5 again and phase_out=8'hA5 one cycle later.
